target_tracker: RTL and testbench



---
 rtl/target_tracker.sv | 172 +++++++++++++++++
 tb/tb_target_tracker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/target_tracker.sv
// Four-slot target tracker: snapshots per-frame marker reports, smooths them into
// locked tracks, and streams one record per slot over a valid/ready handshake.
module target_tracker #(
    parameter  int SCREEN_WIDTH  = 1280,
    parameter  int SCREEN_HEIGHT = 720,
    parameter  int ALPHA_SHIFT   = 2,
    parameter  int MAX_MISS      = 3,
    localparam int X_W           = $clog2(SCREEN_WIDTH),
    localparam int Y_W           = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           frame_in,
    input  logic [X_W-1:0] xcount0_in,
    input  logic [X_W-1:0] xcount1_in,
    input  logic [X_W-1:0] xcount2_in,
    input  logic [X_W-1:0] xcount3_in,
    input  logic [Y_W-1:0] ycount0_in,
    input  logic [Y_W-1:0] ycount1_in,
    input  logic [Y_W-1:0] ycount2_in,
    input  logic [Y_W-1:0] ycount3_in,
    input  logic [Y_W-1:0] diameter0_in,
    input  logic [Y_W-1:0] diameter1_in,
    input  logic [Y_W-1:0] diameter2_in,
    input  logic [Y_W-1:0] diameter3_in,
    input  logic [3:0]     valid_in,
    output logic           rec_valid_out,
    input  logic           rec_ready_in,
    output logic [1:0]     rec_id_out,
    output logic [X_W-1:0] rec_x_out,
    output logic [Y_W-1:0] rec_y_out,
    output logic [Y_W-1:0] rec_d_out,
    output logic           rec_locked_out,
    output logic           busy_out,
    output logic [7:0]     overrun_out
);

    localparam int         MW         = (X_W > Y_W) ? X_W : Y_W;
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    typedef enum logic [1:0] {IDLE, FILTER, EMIT} state_t;

    state_t         state;
    logic [1:0]     ptr;
    logic [1:0]     ptr_nxt;
    logic [3:0]     miss_inc;

    logic [X_W-1:0] snap_x [4];
    logic [Y_W-1:0] snap_y [4];
    logic [Y_W-1:0] snap_d [4];
    logic [3:0]     snap_v;

    logic [X_W-1:0] trk_x [4];
    logic [Y_W-1:0] trk_y [4];
    logic [Y_W-1:0] trk_d [4];
    logic [3:0]     trk_locked;
    logic [3:0]     trk_miss [4];

    // v + ((new - v) >>> ALPHA_SHIFT); the result lies between old and new, so
    // wrapping the addition back to MW bits is exact.
    function automatic logic [MW-1:0] smooth(input logic [MW-1:0] old_v,
                                             input logic [MW-1:0] new_v);
        logic signed [MW:0] diff;
        diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
        diff = diff >>> ALPHA_SHIFT;
        return old_v + diff[MW-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        miss_inc = trk_miss[ptr];
        if (miss_inc != 4'hF) miss_inc = miss_inc + 4'd1;
        ptr_nxt = ptr + 2'd1;
    end

    // NOTE: the snapshot is always written before it is read, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (state == IDLE && frame_in) begin
            snap_x[0] <= xcount0_in;   snap_x[1] <= xcount1_in;
            snap_x[2] <= xcount2_in;   snap_x[3] <= xcount3_in;
            snap_y[0] <= ycount0_in;   snap_y[1] <= ycount1_in;
            snap_y[2] <= ycount2_in;   snap_y[3] <= ycount3_in;
            snap_d[0] <= diameter0_in; snap_d[1] <= diameter1_in;
            snap_d[2] <= diameter2_in; snap_d[3] <= diameter3_in;
            snap_v    <= {valid_in[0], valid_in[1], valid_in[2], valid_in[3]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ptr            <= 2'd0;
            trk_locked     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                trk_x[i]    <= '0;
                trk_y[i]    <= '0;
                trk_d[i]    <= '0;
                trk_miss[i] <= 4'd0;
            end
            rec_valid_out  <= 1'b0;
            rec_id_out     <= 2'd0;
            rec_x_out      <= '0;
            rec_y_out      <= '0;
            rec_d_out      <= '0;
            rec_locked_out <= 1'b0;
            busy_out       <= 1'b0;
            overrun_out    <= 8'd0;
        end else begin
            if (frame_in && state != IDLE && overrun_out != 8'hFF)
                overrun_out <= overrun_out + 8'd1;

            case (state)
                IDLE: begin
                    if (frame_in) begin
                        state    <= FILTER;
                        ptr      <= 2'd0;
                        busy_out <= 1'b1;
                    end
                end
                FILTER: begin
                    if (snap_v[ptr]) begin
                        if (trk_locked[ptr]) begin
                            trk_x[ptr] <= X_W'(smooth(MW'(trk_x[ptr]), MW'(snap_x[ptr])));
                            trk_y[ptr] <= Y_W'(smooth(MW'(trk_y[ptr]), MW'(snap_y[ptr])));
                            trk_d[ptr] <= Y_W'(smooth(MW'(trk_d[ptr]), MW'(snap_d[ptr])));
                        end else begin
                            trk_x[ptr] <= snap_x[ptr];
                            trk_y[ptr] <= snap_y[ptr];
                            trk_d[ptr] <= snap_d[ptr];
                        end
                        trk_locked[ptr] <= 1'b1;
                        trk_miss[ptr]   <= 4'd0;
                    end else begin
                        trk_miss[ptr] <= miss_inc;
                        if (miss_inc >= MISS_LIMIT) trk_locked[ptr] <= 1'b0;
                    end
                    ptr <= ptr_nxt;
                    // Slot 0 finished three edges ago, so its record can be loaded now.
                    if (ptr == 2'd3) begin
                        state          <= EMIT;
                        rec_valid_out  <= 1'b1;
                        rec_id_out     <= 2'd0;
                        rec_x_out      <= trk_x[0];
                        rec_y_out      <= trk_y[0];
                        rec_d_out      <= trk_d[0];
                        rec_locked_out <= trk_locked[0];
                    end
                end
                EMIT: begin
                    if (rec_ready_in) begin
                        if (ptr == 2'd3) begin
                            state         <= IDLE;
                            ptr           <= 2'd0;
                            rec_valid_out <= 1'b0;
                            busy_out      <= 1'b0;
                        end else begin
                            ptr            <= ptr_nxt;
                            rec_id_out     <= ptr_nxt;
                            rec_x_out      <= trk_x[ptr_nxt];
                            rec_y_out      <= trk_y[ptr_nxt];
                            rec_d_out      <= trk_d[ptr_nxt];
                            rec_locked_out <= trk_locked[ptr_nxt];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench for target_tracker: smoothing, lock loss, backpressure, overrun
// and asynchronous reset, with hand-computed expected records.
module tb_target_tracker;

    localparam int X_W = 11;
    localparam int Y_W = 11;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           frame_in = 1'b0;
    logic           rec_ready_in = 1'b1;
    logic [X_W-1:0] xc [4];
    logic [Y_W-1:0] yc [4];
    logic [Y_W-1:0] dc [4];
    logic [3:0]     valid_in = 4'd0;
    logic           rec_valid_out;
    logic [1:0]     rec_id_out;
    logic [X_W-1:0] rec_x_out;
    logic [Y_W-1:0] rec_y_out;
    logic [Y_W-1:0] rec_d_out;
    logic           rec_locked_out;
    logic           busy_out;
    logic [7:0]     overrun_out;

    int exp_x [4];
    int exp_y [4];
    int exp_d [4];
    int exp_l [4];
    int checks = 0;
    int errors = 0;

    target_tracker #(
        .SCREEN_WIDTH(1280), .SCREEN_HEIGHT(720), .ALPHA_SHIFT(2), .MAX_MISS(3)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in),
        .xcount0_in(xc[0]), .xcount1_in(xc[1]), .xcount2_in(xc[2]), .xcount3_in(xc[3]),
        .ycount0_in(yc[0]), .ycount1_in(yc[1]), .ycount2_in(yc[2]), .ycount3_in(yc[3]),
        .diameter0_in(dc[0]), .diameter1_in(dc[1]), .diameter2_in(dc[2]), .diameter3_in(dc[3]),
        .valid_in(valid_in),
        .rec_valid_out(rec_valid_out), .rec_ready_in(rec_ready_in),
        .rec_id_out(rec_id_out), .rec_x_out(rec_x_out), .rec_y_out(rec_y_out),
        .rec_d_out(rec_d_out), .rec_locked_out(rec_locked_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_tgt(input int i, input int x, input int y, input int d);
        xc[i] = X_W'(x);
        yc[i] = Y_W'(y);
        dc[i] = Y_W'(d);
    endtask

    task automatic set_exp(input int i, input int x, input int y, input int d, input int l);
        exp_x[i] = x;
        exp_y[i] = y;
        exp_d[i] = d;
        exp_l[i] = l;
    endtask

    task automatic check_rec(input int n);
        check($sformatf("id%0d", n),     32'(rec_id_out),     n);
        check($sformatf("x%0d", n),      32'(rec_x_out),      exp_x[n]);
        check($sformatf("y%0d", n),      32'(rec_y_out),      exp_y[n]);
        check($sformatf("d%0d", n),      32'(rec_d_out),      exp_d[n]);
        check($sformatf("locked%0d", n), 32'(rec_locked_out), exp_l[n]);
    endtask

    task automatic strobe();
        frame_in = 1'b1;
        @(posedge clk_in); #1;
        frame_in = 1'b0;
        check("busy_rise", 32'(busy_out), 1);
    endtask

    // Collects the four records; cycle numbers count edges after the strobe edge.
    task automatic collect(input int first_exp, input int stall_rec, input int stall_len,
                           input int extra_edge, input bit strobe_last);
        int n = 0;
        int cyc = 0;
        int first = -1;
        rec_ready_in = 1'b1;
        while (n < 4 && cyc <= 40) begin
            if (rec_valid_out) begin
                if (n == 0) first = cyc;
                check_rec(n);
                if (n == stall_rec) begin
                    rec_ready_in = 1'b0;
                    repeat (stall_len) begin
                        @(posedge clk_in); #1;
                        cyc++;
                        check("stall_valid", 32'(rec_valid_out), 1);
                        check_rec(n);
                    end
                    rec_ready_in = 1'b1;
                end
                if (n == 3 && strobe_last) frame_in = 1'b1;
                n++;
            end
            if (n < 4) begin
                frame_in = (extra_edge > 0 && cyc + 1 == extra_edge);
                @(posedge clk_in); #1;
                cyc++;
                frame_in = 1'b0;
            end
        end
        check("rec_count", n, 4);
        if (first_exp >= 0) check("first_cycle", first, first_exp);
        @(posedge clk_in); #1;
        frame_in = 1'b0;
        check("post_valid", 32'(rec_valid_out), 0);
        check("post_busy", 32'(busy_out), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            set_tgt(i, 1111, 1111, 1111);
            set_exp(i, 0, 0, 0, 0);
        end

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid",   32'(rec_valid_out),  0);
        check("rst_busy",    32'(busy_out),       0);
        check("rst_overrun", 32'(overrun_out),    0);
        check("rst_id",      32'(rec_id_out),     0);
        check("rst_x",       32'(rec_x_out),      0);
        check("rst_locked",  32'(rec_locked_out), 0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Frame 1: target 0 appears and loads directly.
        valid_in = 4'b1000; set_tgt(0, 100, 200, 30);
        set_exp(0, 100, 200, 30, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // Smoothing toward larger and smaller values (floor rounding on negatives).
        set_tgt(0, 140, 204, 30); set_exp(0, 110, 201, 30, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);
        set_tgt(0, 99, 180, 38);  set_exp(0, 107, 195, 32, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // Target 1 locks; target 0 starts missing.
        valid_in = 4'b0100; set_tgt(1, 500, 300, 20);
        set_exp(1, 500, 300, 20, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // Invalid frames: target 0 unlocks on its third miss, target 1 on the frame after.
        valid_in = 4'b0000;
        strobe(); collect(4, -1, 0, 0, 1'b0);
        set_exp(0, 107, 195, 32, 0);
        strobe(); collect(4, -1, 0, 0, 1'b0);
        set_exp(1, 500, 300, 20, 0);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // Unlocked slots reload directly.
        valid_in = 4'b1100; set_tgt(0, 99, 99, 99); set_tgt(1, 50, 60, 10);
        set_exp(0, 99, 99, 99, 1); set_exp(1, 50, 60, 10, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // A +1 step is below the gain resolution and holds 99.
        valid_in = 4'b1000; set_tgt(0, 100, 100, 100);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        // Backpressure on record 2 for five cycles.
        valid_in = 4'b1010; set_tgt(0, 99, 99, 99); set_tgt(2, 321, 123, 45);
        set_exp(2, 321, 123, 45, 1);
        strobe(); collect(4, 2, 5, 0, 1'b0);

        // Overrun: strobes during FILTER and at the final acceptance are dropped.
        check("ovr_before", 32'(overrun_out), 0);
        valid_in = 4'b1000; set_tgt(0, 103, 99, 95);
        set_exp(0, 100, 99, 98, 1); set_exp(1, 50, 60, 10, 0);
        strobe();
        valid_in = 4'b0111; set_tgt(0, 500, 500, 500);
        set_tgt(1, 1, 2, 3); set_tgt(2, 4, 5, 6); set_tgt(3, 7, 8, 9);
        collect(4, -1, 0, 2, 1'b1);
        check("ovr_two", 32'(overrun_out), 2);

        // Saturation: 300 strobes while EMIT is stalled.
        valid_in = 4'b0000;
        strobe();
        frame_in = 1'b1; rec_ready_in = 1'b0;
        repeat (300) @(posedge clk_in);
        #1;
        frame_in = 1'b0;
        check("ovr_sat", 32'(overrun_out), 255);
        collect(-1, -1, 0, 0, 1'b0);

        // Asynchronous reset in the middle of EMIT.
        strobe();
        repeat (5) @(posedge clk_in);
        #1;
        check("pre_rst_valid", 32'(rec_valid_out), 1);
        check("pre_rst_id",    32'(rec_id_out),    1);
        #2 rst_in = 1'b1;
        #1;
        check("arst_valid",   32'(rec_valid_out),  0);
        check("arst_busy",    32'(busy_out),       0);
        check("arst_overrun", 32'(overrun_out),    0);
        check("arst_id",      32'(rec_id_out),     0);
        check("arst_x",       32'(rec_x_out),      0);
        check("arst_locked",  32'(rec_locked_out), 0);
        #2 rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("rel_valid", 32'(rec_valid_out), 0);

        // Clean restart: only slot 2 is valid, everything else was cleared.
        for (int i = 0; i < 4; i++) set_exp(i, 0, 0, 0, 0);
        valid_in = 4'b0010; set_tgt(2, 7, 8, 9);
        set_exp(2, 7, 8, 9, 1);
        strobe(); collect(4, -1, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
